// File: rtl/cpu_divider.sv
// Iterative radix-2 restoring divider for latent DIVS/DIVU/MODS/MODU.
// Fixed 34-cycle execution, result held until the writeback path acknowledges it.
module cpu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             div_start,
    input  logic [2:0]       div_op,
    input  logic [WIDTH-1:0] div_a,
    input  logic [WIDTH-1:0] div_b,
    input  logic [4:0]       div_dest,
    output logic             p4_divider_busy,
    output logic             div_valid,
    output logic [WIDTH-1:0] div_result,
    output logic [4:0]       div_result_dest,
    input  logic             div_ack
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RUN,
        FIXUP,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [4:0]       dest_q, dest_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] babs_q, babs_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       result_dest_q, result_dest_d;

    logic             is_signed;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign p4_divider_busy = (state_q != IDLE) | div_start;
    assign div_valid       = valid_q;
    assign div_result      = result_q;
    assign div_result_dest = result_dest_q;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        dest_d        = dest_q;
        a_d           = a_q;
        b_d           = b_q;
        quo_d         = quo_q;
        rem_d         = rem_q;
        babs_d        = babs_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        cnt_d         = cnt_q;
        valid_d       = valid_q;
        result_d      = result_q;
        result_dest_d = result_dest_q;
        is_signed     = ~op_q[0];
        shifted       = {rem_q, quo_q[WIDTH-1]};
        trial         = {1'b0, shifted} - {2'b00, babs_q};
        q_fix         = neg_quo_q ? -quo_q : quo_q;
        r_fix         = neg_rem_q ? -rem_q : rem_q;

        case (state_q)
            IDLE: begin
                if (div_start) begin
                    op_d    = div_op;
                    dest_d  = div_dest;
                    a_d     = div_a;
                    b_d     = div_b;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                quo_d     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
                babs_d    = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
                neg_quo_d = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                neg_rem_d = is_signed & a_q[WIDTH-1];
                rem_d     = '0;
                cnt_d     = 5'd31;
                state_d   = RUN;
            end
            RUN: begin
                // trial is one bit wider than shifted so its MSB is the borrow.
                if (!trial[WIDTH+1]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                if (b_q == '0) begin
                    q_fix = '1;
                    r_fix = a_q;
                end
                result_d      = op_q[1] ? r_fix : q_fix;
                result_dest_d = dest_q;
                valid_d       = 1'b1;
                state_d       = DONE;
            end
            DONE: begin
                if (div_ack) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            op_q          <= '0;
            dest_q        <= '0;
            a_q           <= '0;
            b_q           <= '0;
            quo_q         <= '0;
            rem_q         <= '0;
            babs_q        <= '0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            cnt_q         <= '0;
            valid_q       <= 1'b0;
            result_q      <= '0;
            result_dest_q <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            dest_q        <= dest_d;
            a_q           <= a_d;
            b_q           <= b_d;
            quo_q         <= quo_d;
            rem_q         <= rem_d;
            babs_q        <= babs_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            cnt_q         <= cnt_d;
            valid_q       <= valid_d;
            result_q      <= result_d;
            result_dest_q <= result_dest_d;
        end
    end

endmodule

// File: tb/tb_cpu_divider.sv
// Directed-vector bench for cpu_divider: latency, signed/unsigned results,
// divide-by-zero, overflow, backpressure, mid-run reset and back-to-back issue.
module tb_cpu_divider;

    logic        clock;
    logic        reset;
    logic        div_start;
    logic [2:0]  div_op;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [4:0]  div_dest;
    logic        p4_divider_busy;
    logic        div_valid;
    logic [31:0] div_result;
    logic [4:0]  div_result_dest;
    logic        div_ack;

    int unsigned n_vec;
    int unsigned n_miss;

    localparam logic [2:0] OP_DIVS = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_MODS = 3'b110;
    localparam logic [2:0] OP_MODU = 3'b111;

    cpu_divider #(.WIDTH(32)) dut (
        .clock           (clock),
        .reset           (reset),
        .div_start       (div_start),
        .div_op          (div_op),
        .div_a           (div_a),
        .div_b           (div_b),
        .div_dest        (div_dest),
        .p4_divider_busy (p4_divider_busy),
        .div_valid       (div_valid),
        .div_result      (div_result),
        .div_result_dest (div_result_dest),
        .div_ack         (div_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one divide, wait for valid, check latency/busy/result/dest, then ack.
    task automatic do_div(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] dest, input logic [31:0] exp);
        int unsigned lat;
        logic        busy_ok;
        div_op    = op;
        div_a     = a;
        div_b     = b;
        div_dest  = dest;
        div_start = 1'b1;
        tick();
        div_start = 1'b0;
        div_a     = 32'hDEAD_BEEF;
        div_b     = 32'h0000_0001;
        div_dest  = 5'd31;
        lat       = 1;
        busy_ok   = 1'b1;
        while (!div_valid && lat < 60) begin
            if (!p4_divider_busy) busy_ok = 1'b0;
            tick();
            lat++;
        end
        check_eq({tag, "_lat"}, lat, 32'd35);
        check_eq({tag, "_busy_run"}, {31'b0, busy_ok}, 32'd1);
        check_eq({tag, "_res"}, div_result, exp);
        check_eq({tag, "_dest"}, {27'b0, div_result_dest}, {27'b0, dest});
        div_ack = 1'b1;
        #1;
        check_eq({tag, "_busy_ack"}, {31'b0, p4_divider_busy}, 32'd1);
        tick();
        div_ack = 1'b0;
        #1;
        check_eq({tag, "_valid_clr"}, {31'b0, div_valid}, 32'd0);
        check_eq({tag, "_busy_clr"}, {31'b0, p4_divider_busy}, 32'd0);
    endtask

    initial begin
        logic        stable_ok;
        logic        valid_seen;
        int unsigned lat;

        n_vec     = 0;
        n_miss    = 0;
        reset     = 1'b1;
        div_start = 1'b0;
        div_op    = 3'b000;
        div_a     = '0;
        div_b     = '0;
        div_dest  = '0;
        div_ack   = 1'b0;
        tick();
        tick();

        // Reset state; busy follows div_start while idle.
        check_eq("rst_valid", {31'b0, div_valid}, 32'd0);
        check_eq("rst_result", div_result, 32'd0);
        check_eq("rst_dest", {27'b0, div_result_dest}, 32'd0);
        check_eq("rst_busy", {31'b0, p4_divider_busy}, 32'd0);
        div_start = 1'b1;
        #1;
        check_eq("rst_busy_start", {31'b0, p4_divider_busy}, 32'd1);
        div_start = 1'b0;
        reset     = 1'b0;
        tick();

        do_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd5, 32'h0000_000E);
        do_div("divs_m100_7", OP_DIVS, 32'hFFFF_FF9C, 32'd7, 5'd3, 32'hFFFF_FFF2);
        do_div("mods_m100_7", OP_MODS, 32'hFFFF_FF9C, 32'd7, 5'd4, 32'hFFFF_FFFE);
        do_div("modu_100_7", OP_MODU, 32'd100, 32'd7, 5'd6, 32'h0000_0002);
        do_div("divs_100_m7", OP_DIVS, 32'd100, 32'hFFFF_FFF9, 5'd8, 32'hFFFF_FFF2);
        do_div("mods_100_m7", OP_MODS, 32'd100, 32'hFFFF_FFF9, 5'd8, 32'h0000_0002);
        do_div("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 5'd10, 32'h0FFF_FFFF);
        do_div("modu_big", OP_MODU, 32'hFFFF_FFFF, 32'h8000_0000, 5'd11, 32'h7FFF_FFFF);
        do_div("divu_by0", OP_DIVU, 32'h0000_1234, 32'd0, 5'd12, 32'hFFFF_FFFF);
        do_div("divs_by0", OP_DIVS, 32'hFFFF_FFFB, 32'd0, 5'd13, 32'hFFFF_FFFF);
        do_div("mods_by0", OP_MODS, 32'hFFFF_FFFB, 32'd0, 5'd14, 32'hFFFF_FFFB);
        do_div("modu_by0", OP_MODU, 32'h0000_1234, 32'd0, 5'd15, 32'h0000_1234);
        do_div("divs_ovf", OP_DIVS, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000);
        do_div("mods_ovf", OP_MODS, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000);
        do_div("dest0", OP_DIVU, 32'd50, 32'd5, 5'd0, 32'd10);

        // Backpressure: hold ack low, pulse a start that must be ignored.
        div_op    = OP_DIVU;
        div_a     = 32'd1000;
        div_b     = 32'd10;
        div_dest  = 5'd21;
        div_start = 1'b1;
        tick();
        div_start = 1'b0;
        lat       = 1;
        while (!div_valid && lat < 60) begin
            tick();
            lat++;
        end
        check_eq("bp_lat", lat, 32'd35);
        stable_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                div_op    = OP_MODU;
                div_a     = 32'd77;
                div_b     = 32'd5;
                div_dest  = 5'd2;
                div_start = 1'b1;
            end else begin
                div_start = 1'b0;
            end
            tick();
            if (!div_valid || div_result !== 32'd100 || div_result_dest !== 5'd21 ||
                !p4_divider_busy)
                stable_ok = 1'b0;
        end
        div_start = 1'b0;
        check_eq("bp_stable", {31'b0, stable_ok}, 32'd1);
        check_eq("bp_res", div_result, 32'd100);
        check_eq("bp_dest", {27'b0, div_result_dest}, 32'd21);
        div_ack = 1'b1;
        tick();
        div_ack = 1'b0;
        check_eq("bp_valid_clr", {31'b0, div_valid}, 32'd0);
        do_div("bp_after", OP_MODU, 32'd77, 32'd5, 5'd2, 32'd2);

        // Reset during RUN cycle 12.
        div_op    = OP_DIVU;
        div_a     = 32'd500;
        div_b     = 32'd3;
        div_dest  = 5'd9;
        div_start = 1'b1;
        tick();
        div_start = 1'b0;
        for (int i = 0; i < 13; i++) tick();
        check_eq("mid_busy", {31'b0, p4_divider_busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mid_rst_busy", {31'b0, p4_divider_busy}, 32'd0);
        check_eq("mid_rst_valid", {31'b0, div_valid}, 32'd0);
        valid_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (div_valid || p4_divider_busy) valid_seen = 1'b1;
        end
        check_eq("mid_rst_quiet", {31'b0, valid_seen}, 32'd0);
        do_div("after_rst", OP_DIVU, 32'd9, 32'd3, 5'd1, 32'd3);

        // Back-to-back: second start in the cycle right after the first ack.
        do_div("b2b_first", OP_DIVU, 32'd81, 32'd9, 5'd7, 32'd9);
        do_div("b2b_second", OP_MODS, 32'hFFFF_FFEC, 32'd6, 5'd9, 32'hFFFF_FFFE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
